tournament_pred_ctrl: RTL and testbench
=======================================

// Module: tournament_pred_ctrl
// PURPOSE
//  Sequencer for the tournament branch predictor datapath (LHT, local, global and choice predictors, path history).
//  Accepts one branch lookup at a time and holds the PC stable on pc_out.
//  Steps LHT -> LP -> GP/CP reads and emits the final prediction.
//  Waits for branch resolution, then issues a single-cycle update to all tables and shifts path history.
// PARAMETERS
//  PC_W      10  PC width
//  LHT_W     10  local history entry width
//  PH_W      12  path history width
//  HOLD_CYC   8  min cycles pc_out stays stable after accept (>=6)
// PORTS
//  clock        in   1      single clock, all logic on posedge
//  reset        in   1      asynchronous, active-high
//  req_valid    in   1      lookup request
//  req_ready    out  1      high only in IDLE
//  req_pc       in   PC_W   branch PC
//  pc_out       out  PC_W   PC to tables; stable from accept to next accept
//  lht_rd_en    out  1      LHT read strobe
//  lht_data     in   LHT_W  LHT read data
//  lht_hist     out  LHT_W  latched LHT entry (LP index)
//  lp_rd_en     out  1      local predictor read strobe
//  lp_pred      in   1      local prediction
//  gp_rd_en     out  1      global+choice read strobe
//  gp_pred      in   1      global prediction
//  cp_choice    in   1      1 = use global, 0 = use local
//  pred_valid   out  1      one-cycle prediction pulse
//  pred_taken   out  1      final prediction, held until next accept
//  res_valid    in   1      resolution valid
//  res_ready    out  1      high only in WAIT_RES
//  res_taken    in   1      actual outcome (BranchTaken)
//  upd_en       out  1      one-cycle update pulse to LHT/LP/GP
//  upd_taken    out  1      outcome driven with upd_en
//  cp_upd_en    out  1      choice update pulse (subset of upd_en)
//  cp_upd_dir   out  1      1 = move toward global
//  path_hist    out  PH_W   path history register
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs and registers 0, except req_ready=1.
//   Reset mid-operation aborts the branch; no upd_en is issued.
//  States: IDLE -> LHT_RD -> LP_RD -> GP_RD(2 cyc) -> PREDICT -> WAIT_RES -> UPDATE -> HOLD -> IDLE.
//  Cycle 0 = posedge where req_valid&&req_ready; pc_out<=req_pc there.
//  LHT_RD (c1): lht_rd_en=1; lht_hist<=lht_data at end of cycle.
//  LP_RD (c2): lp_rd_en=1; lp_pred latched at end of cycle.
//  GP_RD (c3-c4): gp_rd_en=1 both cycles; gp_pred and cp_choice latched at end of c4.
//  PREDICT (c5): pred_valid=1 for one cycle; pred_taken = cp_choice ? gp : lp (latched values).
//  WAIT_RES: res_ready=1. Stays indefinitely until res_valid; res_valid outside WAIT_RES is ignored.
//  UPDATE (1 cyc): upd_en=1 and upd_taken=res_taken (latched). path_hist <= {path_hist[PH_W-2:0],res_taken}.
//   cp_upd_en=1 only if lp!=gp; cp_upd_dir=(gp==res_taken).
//  HOLD: counter runs from accept; exit to IDLE when count>=HOLD_CYC. Skipped if already reached.
//  PC changes only on accept. pc_out is never unknown after reset.
//  path_hist shifts only in UPDATE. Oldest bit dropped; no saturation.
// CONFIGURATION
//  PRED_STATS_EN defined: adds mispred_cnt (out,16) and branch_cnt (out,16).
//   Both increment in UPDATE; mispred_cnt only when pred_taken!=res_taken.
//   Both wrap at 0xFFFF->0 and reset to 0.
//  PRED_STATS_EN undefined: these ports and counters are absent.
// TESTING
//  Accept pc=0x155, lht=0x2A, lp=1, gp=0, cp=0 -> pred_valid at c5 with pred_taken=1; pc_out=0x155 for >=8 cycles.
//  Same branch, res_taken=0 at c7 -> upd_en at c8, upd_taken=0, cp_upd_en=1, cp_upd_dir=1, path_hist=0x000.
//  lp=gp=1, res=1 four times -> path_hist=0x00F; cp_upd_en never asserted.
//  req_valid held high back-to-back -> second accept not before c0+HOLD_CYC+1; req_ready=0 meanwhile.
//  Assert reset in WAIT_RES -> immediate IDLE, no upd_en, path_hist=0, pred_taken=0.
//  PRED_STATS_EN: 3 branches with 2 mispredicts -> branch_cnt=3, mispred_cnt=2.

Source files
------------

// File: rtl/tournament_pred_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tournament_pred_ctrl_if
// Purpose  : Lookup, table-read, resolution and update bundle for the
//            tournament predictor sequencer (stats ports under PRED_STATS_EN).
// Revision : 1.0 - initial release
// ============================================================================
interface tournament_pred_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int LHT_W = 10,
  parameter int PH_W  = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [PC_W-1:0]  req_pc;
  logic [PC_W-1:0]  pc_out;
  logic             lht_rd_en;
  logic [LHT_W-1:0] lht_data;
  logic [LHT_W-1:0] lht_hist;
  logic             lp_rd_en;
  logic             lp_pred;
  logic             gp_rd_en;
  logic             gp_pred;
  logic             cp_choice;
  logic             pred_valid;
  logic             pred_taken;
  logic             res_valid;
  logic             res_ready;
  logic             res_taken;
  logic             upd_en;
  logic             upd_taken;
  logic             cp_upd_en;
  logic             cp_upd_dir;
  logic [PH_W-1:0]  path_hist;
  logic             busy;
`ifdef PRED_STATS_EN
  logic [15:0]      mispred_cnt;
  logic [15:0]      branch_cnt;

  modport slave (
    input  req_valid, req_pc, lht_data, lp_pred, gp_pred, cp_choice,
           res_valid, res_taken,
    output req_ready, pc_out, lht_rd_en, lht_hist, lp_rd_en, gp_rd_en,
           pred_valid, pred_taken, res_ready, upd_en, upd_taken,
           cp_upd_en, cp_upd_dir, path_hist, busy, mispred_cnt, branch_cnt
  );
  modport master (
    output req_valid, req_pc, lht_data, lp_pred, gp_pred, cp_choice,
           res_valid, res_taken,
    input  req_ready, pc_out, lht_rd_en, lht_hist, lp_rd_en, gp_rd_en,
           pred_valid, pred_taken, res_ready, upd_en, upd_taken,
           cp_upd_en, cp_upd_dir, path_hist, busy, mispred_cnt, branch_cnt
  );
`else
  modport slave (
    input  req_valid, req_pc, lht_data, lp_pred, gp_pred, cp_choice,
           res_valid, res_taken,
    output req_ready, pc_out, lht_rd_en, lht_hist, lp_rd_en, gp_rd_en,
           pred_valid, pred_taken, res_ready, upd_en, upd_taken,
           cp_upd_en, cp_upd_dir, path_hist, busy
  );
  modport master (
    output req_valid, req_pc, lht_data, lp_pred, gp_pred, cp_choice,
           res_valid, res_taken,
    input  req_ready, pc_out, lht_rd_en, lht_hist, lp_rd_en, gp_rd_en,
           pred_valid, pred_taken, res_ready, upd_en, upd_taken,
           cp_upd_en, cp_upd_dir, path_hist, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tournament_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tournament_pred_ctrl
// Purpose  : Sequences LHT -> LP -> GP/CP reads, emits the tournament
//            prediction, then updates tables and path history on resolution.
//            Define PRED_STATS_EN to add branch/mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module tournament_pred_ctrl #(
  parameter int PC_W     = 10,
  parameter int LHT_W    = 10,
  parameter int PH_W     = 12,
  parameter int HOLD_CYC = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  tournament_pred_ctrl_if.slave tp_if
);
  localparam int               CNT_W  = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] c_hold = CNT_W'(HOLD_CYC);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LHT_RD   = 4'd1,
    S_LP_RD    = 4'd2,
    S_GP_RD0   = 4'd3,
    S_GP_RD1   = 4'd4,
    S_PREDICT  = 4'd5,
    S_WAIT_RES = 4'd6,
    S_UPDATE   = 4'd7,
    S_HOLD     = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [LHT_W-1:0] lht_q, lht_d;
  logic             lp_q, lp_d;
  logic             gp_q, gp_d;
  logic             pred_q, pred_d;
  logic             res_q, res_d;
  logic [PH_W-1:0]  path_q, path_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PRED_STATS_EN
  logic [15:0]      bcnt_q, bcnt_d;
  logic [15:0]      mcnt_q, mcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    lht_d   = lht_q;
    lp_d    = lp_q;
    gp_d    = gp_q;
    pred_d  = pred_q;
    res_d   = res_q;
    path_d  = path_q;
    cnt_d   = cnt_q;
`ifdef PRED_STATS_EN
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
`endif
    // Counter holds the cycle index since accept; saturates once the hold is met.
    if ((state_q != S_IDLE) && (cnt_q < c_hold)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tp_if.req_valid) begin
          state_d = S_LHT_RD;
          pc_d    = tp_if.req_pc;
          cnt_d   = CNT_W'(1);
        end
      end
      S_LHT_RD: begin
        lht_d   = tp_if.lht_data;
        state_d = S_LP_RD;
      end
      S_LP_RD: begin
        lp_d    = tp_if.lp_pred;
        state_d = S_GP_RD0;
      end
      S_GP_RD0: state_d = S_GP_RD1;
      S_GP_RD1: begin
        gp_d    = tp_if.gp_pred;
        pred_d  = tp_if.cp_choice ? tp_if.gp_pred : lp_q;
        state_d = S_PREDICT;
      end
      S_PREDICT: state_d = S_WAIT_RES;
      S_WAIT_RES: begin
        if (tp_if.res_valid) begin
          res_d   = tp_if.res_taken;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        path_d  = {path_q[PH_W-2:0], res_q};
`ifdef PRED_STATS_EN
        bcnt_d  = bcnt_q + 16'd1;
        if (pred_q != res_q) begin
          mcnt_d = mcnt_q + 16'd1;
        end
`endif
        state_d = (cnt_q >= c_hold) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q >= c_hold) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      lht_q   <= '0;
      lp_q    <= 1'b0;
      gp_q    <= 1'b0;
      pred_q  <= 1'b0;
      res_q   <= 1'b0;
      path_q  <= '0;
      cnt_q   <= '0;
`ifdef PRED_STATS_EN
      bcnt_q  <= '0;
      mcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lht_q   <= lht_d;
      lp_q    <= lp_d;
      gp_q    <= gp_d;
      pred_q  <= pred_d;
      res_q   <= res_d;
      path_q  <= path_d;
      cnt_q   <= cnt_d;
`ifdef PRED_STATS_EN
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
`endif
    end
  end

  logic w_upd;
  assign w_upd = (state_q == S_UPDATE);

  assign tp_if.req_ready  = (state_q == S_IDLE);
  assign tp_if.busy       = (state_q != S_IDLE);
  assign tp_if.pc_out     = pc_q;
  assign tp_if.lht_rd_en  = (state_q == S_LHT_RD);
  assign tp_if.lht_hist   = lht_q;
  assign tp_if.lp_rd_en   = (state_q == S_LP_RD);
  assign tp_if.gp_rd_en   = (state_q == S_GP_RD0) || (state_q == S_GP_RD1);
  assign tp_if.pred_valid = (state_q == S_PREDICT);
  assign tp_if.pred_taken = pred_q;
  assign tp_if.res_ready  = (state_q == S_WAIT_RES);
  assign tp_if.upd_en     = w_upd;
  assign tp_if.upd_taken  = w_upd & res_q;
  // Choice table only learns when the two component predictors disagreed.
  assign tp_if.cp_upd_en  = w_upd & (lp_q ^ gp_q);
  assign tp_if.cp_upd_dir = w_upd & (gp_q ~^ res_q);
  assign tp_if.path_hist  = path_q;
`ifdef PRED_STATS_EN
  assign tp_if.branch_cnt  = bcnt_q;
  assign tp_if.mispred_cnt = mcnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tournament_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_pred_ctrl
// Purpose  : Randomized scoreboard bench for tournament_pred_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_pred_ctrl;
  localparam int PC_W     = 10;
  localparam int LHT_W    = 10;
  localparam int PH_W     = 12;
  localparam int HOLD_CYC = 8;
  localparam int BOUND    = 100;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  tournament_pred_ctrl_if #(.PC_W(PC_W), .LHT_W(LHT_W), .PH_W(PH_W)) bus ();

  tournament_pred_ctrl #(
    .PC_W(PC_W), .LHT_W(LHT_W), .PH_W(PH_W), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tp_if(bus)
  );

  typedef struct {
    int               a;
    logic [PC_W-1:0]  pc;
    logic [LHT_W-1:0] lht;
    logic             pred;
  } pexp_t;
  typedef struct {
    int              r;
    logic            taken;
    logic            cpen;
    logic            cpdir;
    logic [PH_W-1:0] path;
    logic [15:0]     bc;
    logic [15:0]     mc;
  } uexp_t;

  pexp_t pq[$];
  uexp_t uq[$];
  pexp_t pe;
  uexp_t ue;
  uexp_t last_u;
  bit    post_upd = 1'b0;
  bit    mon_en   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference state: what the tables and counters should hold per the rules.
  logic [PC_W-1:0]  acc_pc = '0;
  logic [PH_W-1:0]  m_path = '0;
  logic [15:0]      m_bc   = '0;
  logic [15:0]      m_mc   = '0;
  int               prev_a   = -1;
  int               exp_next = -1;
  logic [LHT_W-1:0] t_lht = '0;
  logic             t_lp = 1'b0, t_gp = 1'b0, t_cp = 1'b0;
  bit               gp_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout_%s: no response within %0d cycles (cycle %0d)", nm, BOUND, cyc);
    finish_run();
  endtask

  // Table model: true data only in the cycle the sequencer should sample it.
  always @(negedge clk_i) begin
    bus.lht_data  = bus.lht_rd_en ? t_lht : ~t_lht;
    bus.lp_pred   = bus.lp_rd_en ? t_lp : ~t_lp;
    bus.gp_pred   = (bus.gp_rd_en && gp_prev) ? t_gp : ~t_gp;
    bus.cp_choice = (bus.gp_rd_en && gp_prev) ? t_cp : ~t_cp;
    gp_prev       = bus.gp_rd_en;
  end

  always @(negedge clk_i) begin
    if (mon_en && !rst_i) begin
      if (post_upd) begin
        chk("path_hist", bus.path_hist, last_u.path);
`ifdef PRED_STATS_EN
        chk("branch_cnt", bus.branch_cnt, last_u.bc);
        chk("mispred_cnt", bus.mispred_cnt, last_u.mc);
`endif
        post_upd = 1'b0;
      end
      chk("ready_vs_busy", bus.req_ready, !bus.busy);
      if (bus.busy) chk("pc_stable", bus.pc_out, acc_pc);
      if (bus.pred_valid) begin
        if (pq.size() == 0) begin
          checks++; errors++;
          $display("FAIL pred_unexpected: pred_valid=1 required 0 (cycle %0d)", cyc);
        end else begin
          pe = pq.pop_front();
          chk("pred_latency", cyc - pe.a, 4);
          chk("pred_taken", bus.pred_taken, pe.pred);
          chk("lht_hist", bus.lht_hist, pe.lht);
          chk("pred_pc", bus.pc_out, pe.pc);
        end
      end
      if (bus.upd_en) begin
        if (uq.size() == 0) begin
          checks++; errors++;
          $display("FAIL upd_unexpected: upd_en=1 required 0 (cycle %0d)", cyc);
        end else begin
          ue = uq.pop_front();
          chk("upd_cycle", cyc, ue.r);
          chk("upd_taken", bus.upd_taken, ue.taken);
          chk("cp_upd_en", bus.cp_upd_en, ue.cpen);
          if (ue.cpen) chk("cp_upd_dir", bus.cp_upd_dir, ue.cpdir);
          last_u   = ue;
          post_upd = 1'b1;
        end
      end else begin
        chk("cp_upd_idle", bus.cp_upd_en, 0);
      end
    end
  end

  task automatic run_txn(input logic [PC_W-1:0] pc, input logic [LHT_W-1:0] lht,
                         input logic lp, input logic gp, input logic cp, input logic res,
                         input int dly, input int idle, input bit abort);
    int a, r, n;
    bit exact;
    logic pred;
    exact = (idle == 0) && bus.req_valid;
    if (idle > 0) begin
      bus.req_valid = 1'b0;
      repeat (idle) @(negedge clk_i);
    end
    bus.req_pc = pc;
    t_lht = lht; t_lp = lp; t_gp = gp; t_cp = cp;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready) begin
      @(negedge clk_i);
      n++;
      if (n > BOUND) timeout("accept");
    end
    a = cyc + 1;
    if (prev_a >= 0) begin
      if (exact) chk("accept_gap", a, exp_next);
      else       chk("accept_late", a >= exp_next, 1);
    end
    acc_pc = pc;
    pred   = cp ? gp : lp;
    pq.push_back('{a, pc, lht, pred});
    @(negedge clk_i);
    bus.req_pc = PC_W'($urandom);
    n = 0;
    while (!bus.res_ready) begin
      bus.res_valid = 1'($urandom);
      bus.res_taken = 1'($urandom);
      @(negedge clk_i);
      n++;
      if (n > BOUND) timeout("res_ready");
    end
    bus.res_valid = 1'b0;
    if (abort) begin
      rst_i = 1'b1;
      bus.req_valid = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_ready", bus.req_ready, 1);
      chk("abort_upd", bus.upd_en, 0);
      chk("abort_path", bus.path_hist, 0);
      chk("abort_pred", bus.pred_taken, 0);
      chk("abort_pc", bus.pc_out, 0);
`ifdef PRED_STATS_EN
      chk("abort_bcnt", bus.branch_cnt, 0);
      chk("abort_mcnt", bus.mispred_cnt, 0);
`endif
      m_path = '0; m_bc = '0; m_mc = '0;
      prev_a = -1;
      @(negedge clk_i);
      rst_i = 1'b0;
      return;
    end
    repeat (dly) @(negedge clk_i);
    bus.res_valid = 1'b1;
    bus.res_taken = res;
    r = cyc + 1;
    m_path = {m_path[PH_W-2:0], res};
    m_bc   = m_bc + 16'd1;
    if (pred != res) m_mc = m_mc + 16'd1;
    uq.push_back('{r, res, lp != gp, gp == res, m_path, m_bc, m_mc});
    prev_a   = a;
    exp_next = (a + HOLD_CYC + 1 > r + 2) ? a + HOLD_CYC + 1 : r + 2;
    @(negedge clk_i);
    bus.res_valid = 1'b0;
    bus.res_taken = 1'($urandom);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.res_valid = 1'b0;
    bus.res_taken = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pc", bus.pc_out, 0);
    chk("rst_path", bus.path_hist, 0);
    chk("rst_pred", bus.pred_taken, 0);
    chk("rst_lht", bus.lht_hist, 0);
    chk("rst_strobes", {bus.lht_rd_en, bus.lp_rd_en, bus.gp_rd_en, bus.pred_valid,
                        bus.res_ready, bus.upd_en, bus.cp_upd_en}, 0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk_i);

    run_txn(10'h155, 10'h02A, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run_txn(PC_W'($urandom), LHT_W'($urandom), 1'b1, 1'b1, 1'($urandom), 1'b1,
              int'($urandom_range(0, 3)), 0, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk_i);
    chk("path_0F", bus.path_hist, 12'h00F);

    for (int i = 0; i < 20; i++)
      run_txn(PC_W'($urandom), LHT_W'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);

    run_txn(PC_W'($urandom), LHT_W'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1);

    run_txn(PC_W'($urandom), LHT_W'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);
    run_txn(PC_W'($urandom), LHT_W'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
    run_txn(PC_W'($urandom), LHT_W'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    bus.req_valid = 1'b0;
    @(negedge clk_i);
`ifdef PRED_STATS_EN
    chk("stats_branch3", bus.branch_cnt, 3);
    chk("stats_mispred2", bus.mispred_cnt, 2);
`endif

    for (int i = 0; i < 20; i++)
      run_txn(PC_W'($urandom), LHT_W'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
    bus.req_valid = 1'b0;
    repeat (15) @(negedge clk_i);
    chk("pred_queue_empty", pq.size(), 0);
    chk("upd_queue_empty", uq.size(), 0);
    chk("final_path", bus.path_hist, m_path);
    finish_run();
  end

  initial begin
    #200000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    finish_run();
  end

endmodule
`default_nettype wire
